// File: rtl/firewall_if.sv
// firewall_if: dibit stream into the filter plus filtered payload and drop pulse out.
interface firewall_if;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiov;
    logic [1:0] axiod;
    logic       dropped;
    modport master (output axiiv, axiid, input axiov, axiod, dropped);
    modport slave  (input axiiv, axiid, output axiov, axiod, dropped);
endinterface

// File: rtl/firewall.sv
// firewall: destination-MAC filter that strips the 14-byte header and forwards payload dibits one cycle later.
module firewall #(
    parameter logic [47:0] MAC = 48'h69_69_5A_06_54_91
) (
    input logic        clk,
    input logic        rst,
    firewall_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, DST, HDR, PASS, DROP, SKIP} state_t;
    state_t     state, state_n;
    logic [5:0] cnt, cnt_n;
    logic       own_ok, own_n, bcast_ok, bcast_n;
    logic       ov_n, drop_n;
    logic [1:0] od_n;
    logic [47:0] mac_sh;
    logic       own_chk, bcast_chk;
    // cnt is 0 in IDLE, so the same shifted compare covers index 0 and 1..23
    assign mac_sh    = MAC << {cnt, 1'b0};
    assign own_chk   = own_ok && bus.axiid == mac_sh[47:46];
    assign bcast_chk = bcast_ok && bus.axiid == 2'b11;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SKIP;
            cnt       <= '0;
            own_ok    <= 1'b1;
            bcast_ok  <= 1'b1;
            bus.axiov <= 1'b0;
            bus.axiod <= 2'b00;
            bus.dropped <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            own_ok    <= own_n;
            bcast_ok  <= bcast_n;
            bus.axiov <= ov_n;
            bus.axiod <= od_n;
            bus.dropped <= drop_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        own_n   = own_ok;
        bcast_n = bcast_ok;
        ov_n    = 1'b0;
        od_n    = 2'b00;
        drop_n  = 1'b0;
        if (!bus.axiiv) begin
            state_n = IDLE;
            cnt_n   = '0;
            own_n   = 1'b1;
            bcast_n = 1'b1;
        end else begin
            case (state)
                IDLE, DST: begin
                    own_n   = own_chk;
                    bcast_n = bcast_chk;
                    cnt_n   = cnt + 6'd1;
                    if (state == IDLE) state_n = DST;
                    else if (cnt == 6'd23) begin
                        state_n = (own_chk || bcast_chk) ? HDR : DROP;
                        drop_n  = !(own_chk || bcast_chk);
                    end
                end
                HDR: begin
                    cnt_n = cnt + 6'd1;
                    if (cnt == 6'd55) state_n = PASS;
                end
                PASS: begin
                    ov_n = 1'b1;
                    od_n = bus.axiid;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_firewall.sv
// tb_firewall: directed and random frames checked cycle by cycle against a frame-level model.
module tb_firewall;
    localparam logic [47:0] MAC = 48'h69_69_5A_06_54_91;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [1:0] frm[$];
    firewall_if bus ();
    firewall #(.MAC(MAC)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        frm.push_back(b[7:6]);
        frm.push_back(b[5:4]);
        frm.push_back(b[3:2]);
        frm.push_back(b[1:0]);
    endtask

    task automatic build(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] etype,
                         input logic [7:0] pay[$]);
        frm.delete();
        for (int i = 5; i >= 0; i--) push_byte(dest[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) push_byte(src[i*8 +: 8]);
        push_byte(etype[15:8]);
        push_byte(etype[7:0]);
        foreach (pay[i]) push_byte(pay[i]);
    endtask

    // Frame-level model: accepted if dest is ours or broadcast; payload is every dibit from 56 on;
    // a reject is reported only once all 24 destination dibits were seen.
    task automatic send(input logic [47:0] dest, input int len, input int gap, input int rst_at);
        bit acc = (dest == MAC) || (dest == 48'hFFFF_FFFF_FFFF);
        int n_out = 0;
        for (int k = 0; k < len + gap; k++) begin
            int idx = k - 1;
            bit eo;
            logic [1:0] od;
            @(negedge clk);
            if (rst_at >= 0 && k == rst_at + 1) rst = 1'b0;
            eo = acc && idx >= 56 && idx < len && (rst_at < 0 || idx < rst_at);
            od = 2'b00;
            if (eo) begin
                od = frm[idx];
                n_out++;
            end
            chk("axiov", bus.axiov, eo);
            chk("axiod", bus.axiod, od);
            chk("dropped", bus.dropped, k == 24 && len >= 24 && !acc && !(rst_at >= 0 && rst_at <= 23));
            bus.axiiv = k < len;
            bus.axiid = k < len ? frm[k] : 2'b00;
            if (k == rst_at) begin
                #2 rst = 1'b1;
                #1 chk("async_rst", bus.axiov, 0);
            end
        end
    endtask

    initial begin
        logic [7:0] pay[$];
        logic [47:0] dest;
        bus.axiiv = 1'b0;
        bus.axiid = 2'b00;
        #5;
        chk("rst_axiov", bus.axiov, 0);
        chk("rst_axiod", bus.axiod, 0);
        chk("rst_dropped", bus.dropped, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pay = '{8'hA5, 8'h3C};
        build(MAC, 48'h00_11_22_33_44_55, 16'h0800, pay);
        send(MAC, frm.size(), 2, -1);
        pay = '{8'h01, 8'h02, 8'h03, 8'h04};
        build(48'hFFFF_FFFF_FFFF, 48'h00_11_22_33_44_55, 16'h0800, pay);
        send(48'hFFFF_FFFF_FFFF, frm.size(), 1, -1);
        build(48'h69_69_5A_06_54_90, 48'h00_11_22_33_44_55, 16'h0800, pay);
        send(48'h69_69_5A_06_54_90, frm.size(), 1, -1);
        build(MAC, 48'h00_11_22_33_44_55, 16'h0800, pay);
        send(MAC, 30, 1, -1);
        send(MAC, frm.size(), 1, -1);
        build(48'hFFFF_5A06_5491, 48'h00_11_22_33_44_55, 16'h0800, pay);
        send(48'hFFFF_5A06_5491, frm.size(), 1, -1);
        build(48'hFFFF_FFFF_FFFF, 48'h0, 16'h0800, pay);
        send(48'hFFFF_FFFF_FFFF, 24, 1, -1);
        build(48'h0, 48'h0, 16'h0800, pay);
        send(48'h0, 24, 1, -1);
        pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};
        build(MAC, 48'h00_11_22_33_44_55, 16'h0800, pay);
        send(MAC, frm.size(), 1, 70);
        send(MAC, frm.size(), 1, -1);
        for (int f = 0; f < 60; f++) begin
            int len;
            case ($urandom_range(0, 3))
                0: dest = MAC;
                1: dest = 48'hFFFF_FFFF_FFFF;
                2: dest = MAC ^ (48'd1 << $urandom_range(0, 47));
                default: dest = {$urandom, $urandom};
            endcase
            pay.delete();
            repeat ($urandom_range(0, 12)) pay.push_back(8'($urandom));
            build(dest, {$urandom, $urandom}, 16'($urandom), pay);
            len = $urandom_range(0, 3) == 0 ? $urandom_range(1, frm.size()) : frm.size();
            send(dest, len, $urandom_range(1, 3), -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
